// File: rtl/rand_sel_lfsr.sv
// rand_sel_lfsr: pseudo-random target selector for the whack-a-mole game.
// A maximal-length Fibonacci LFSR runs every cycle. A draw uses rejection
// sampling to give uniform indices in [OFFSET, OFFSET+RANGE-1]. It can
// optionally refuse to repeat the previous pick, and it falls back to a
// deterministic value after MAX_TRIES rejected candidates.
// The result port is rand_val because "rand" is a SystemVerilog keyword.
//
// Handshake: req is a level input that is sampled only in IDLE. A req
// raised while busy is dropped, not queued. valid is a one-cycle pulse that
// qualifies rand_val, and fallback is asserted in the same cycle. There is
// no backpressure: the consumer must take rand_val when valid is high.
// rand_val holds its value until the next valid or a reset.
module rand_sel_lfsr #(
  parameter int unsigned       LFSR_W    = 16,
  parameter int unsigned       RANGE     = 30,
  parameter int unsigned       OUT_W     = 5,
  parameter int unsigned       OFFSET    = 1,
  parameter bit                NO_REPEAT = 1'b1,
  parameter int unsigned       MAX_TRIES = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst_n,      // active-HIGH synchronous reset
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  rand_val,
  output logic              fallback,
  output logic [LFSR_W-1:0] dbg_lfsr,   // current LFSR contents
  output logic [0:0]        dbg_state   // 0 = IDLE, 1 = DRAW
);

  localparam int unsigned K  = $clog2(RANGE);
  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  // Feedback tap masks (bit 0 = LSB) for each supported width
  localparam logic [31:0] TAPS32 = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                   (LFSR_W == 16) ? 32'h0000_B400 :
                                   (LFSR_W == 24) ? 32'h00E1_0000 :
                                                    32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAP_MASK = TAPS32[LFSR_W-1:0];

  // Elaboration-time parameter legality checks
  generate
    if (!(LFSR_W == 8 || LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
      $error("rand_sel_lfsr: LFSR_W must be 8, 16, 24 or 32");
    end
    if (RANGE < 2 || 64'(RANGE) > (64'd1 << OUT_W)) begin : g_bad_range
      $error("rand_sel_lfsr: RANGE must satisfy 2 <= RANGE <= 2**OUT_W");
    end
    if ((64'(OFFSET) + 64'(RANGE) - 64'd1) >= (64'd1 << OUT_W)) begin : g_bad_offset
      $error("rand_sel_lfsr: OFFSET+RANGE-1 does not fit in OUT_W bits");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
      $error("rand_sel_lfsr: MAX_TRIES must be at least 1");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("rand_sel_lfsr: SEED must be nonzero");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [LFSR_W-1:0]  lfsr_q,     lfsr_d;
  logic [TW-1:0]      tries_q,    tries_d;
  logic [K-1:0]       last_q,     last_d;
  logic               last_vld_q, last_vld_d;
  logic [OUT_W-1:0]   rand_q,     rand_d;
  logic               valid_q,    valid_d;
  logic               busy_q,     busy_d;
  logic               fallback_q, fallback_d;

  logic [LFSR_W-1:0]  lfsr_adv;
  logic [K-1:0]       cand;
  logic               reject;
  logic [K-1:0]       fb_sel;

  // Next-state logic: LFSR advance or seed, draw control, output staging
  always_comb begin
    lfsr_adv   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAP_MASK)};
    cand       = lfsr_q[K-1:0];
    reject     = (32'(cand) >= RANGE) ||
                 (NO_REPEAT && last_vld_q && (cand == last_q));
    // Fallback picks the target after the previous one so that it still
    // honours no-repeat. Without a history, it picks index 0.
    fb_sel     = (NO_REPEAT && last_vld_q) ?
                 ((32'(last_q) + 32'd1 == RANGE) ? '0 : last_q + 1'b1) : '0;

    state_d    = state_q;
    tries_d    = tries_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    rand_d     = rand_q;
    valid_d    = 1'b0;
    fallback_d = 1'b0;

    // Seeding overrides the free-running advance. Zero would lock the LFSR.
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr_d = lfsr_adv;
    end

    case (state_q)
      ST_IDLE: begin
        if (req && !seed_load) begin
          state_d = ST_DRAW;
          tries_d = '0;
        end
      end
      ST_DRAW: begin
        if (seed_load) begin
          // A reseed abandons the draw and leaves the last result in place
          state_d = ST_IDLE;
        end else if (!reject) begin
          rand_d     = OUT_W'(OFFSET) + OUT_W'(cand);
          last_d     = cand;
          last_vld_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = ST_IDLE;
        end else if (32'(tries_q) == MAX_TRIES - 1) begin
          rand_d     = OUT_W'(OFFSET) + OUT_W'(fb_sel);
          last_d     = fb_sel;
          last_vld_d = 1'b1;
          valid_d    = 1'b1;
          fallback_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRAW);
  end

  // State and registered outputs, with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      tries_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rand_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tries_q    <= tries_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      rand_q     <= rand_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      fallback_q <= fallback_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign rand_val  = rand_q;
  assign fallback  = fallback_q;
  assign dbg_lfsr  = lfsr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rand_sel_lfsr.sv
// tb_rand_sel_lfsr: directed checks of rand_sel_lfsr in four configurations.
// u0 uses the default 16-bit configuration. u1 through u3 are small 8-bit
// instances whose draw sequences were worked out by hand.
module tb_rand_sel_lfsr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- u0: default configuration ----------------
  logic        sl0 = 1'b0;
  logic [15:0] si0 = '0;
  logic        rq0 = 1'b0;
  logic        busy0, valid0, fb0;
  logic [4:0]  rand0;
  logic [15:0] lfsr0;
  logic [0:0]  st0;

  rand_sel_lfsr #(
    .LFSR_W(16), .RANGE(30), .OUT_W(5), .OFFSET(1),
    .NO_REPEAT(1'b1), .MAX_TRIES(16), .SEED(16'hACE1)
  ) u0 (
    .clk(clk), .rst_n(rst), .seed_load(sl0), .seed_in(si0), .req(rq0),
    .busy(busy0), .valid(valid0), .rand_val(rand0), .fallback(fb0),
    .dbg_lfsr(lfsr0), .dbg_state(st0)
  );

  // ---------------- u1..u3: 8-bit instances sharing stimulus ----------------
  logic       sl8 = 1'b0;
  logic [7:0] si8 = '0;
  logic       rq8 = 1'b0;
  logic       busy1, valid1, fb1, busy2, valid2, fb2, busy3, valid3, fb3;
  logic [2:0] rand1, rand2, rand3;
  logic [7:0] lfsr1, lfsr2, lfsr3;
  logic [0:0] st1, st2, st3;

  rand_sel_lfsr #(
    .LFSR_W(8), .RANGE(4), .OUT_W(3), .OFFSET(0), .NO_REPEAT(1'b0), .MAX_TRIES(16)
  ) u1 (
    .clk(clk), .rst_n(rst), .seed_load(sl8), .seed_in(si8), .req(rq8),
    .busy(busy1), .valid(valid1), .rand_val(rand1), .fallback(fb1),
    .dbg_lfsr(lfsr1), .dbg_state(st1)
  );

  rand_sel_lfsr #(
    .LFSR_W(8), .RANGE(3), .OUT_W(3), .OFFSET(1), .NO_REPEAT(1'b0), .MAX_TRIES(16)
  ) u2 (
    .clk(clk), .rst_n(rst), .seed_load(sl8), .seed_in(si8), .req(rq8),
    .busy(busy2), .valid(valid2), .rand_val(rand2), .fallback(fb2),
    .dbg_lfsr(lfsr2), .dbg_state(st2)
  );

  rand_sel_lfsr #(
    .LFSR_W(8), .RANGE(3), .OUT_W(3), .OFFSET(1), .NO_REPEAT(1'b0), .MAX_TRIES(4)
  ) u3 (
    .clk(clk), .rst_n(rst), .seed_load(sl8), .seed_in(si8), .req(rq8),
    .busy(busy3), .valid(valid3), .rand_val(rand3), .fallback(fb3),
    .dbg_lfsr(lfsr3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [4:0]  exp_q[$];
  logic [15:0] m_lfsr = '0;      // model of u0 LFSR
  logic [4:0]  m_last = '0;      // model of u0 last accepted index
  bit          m_last_vld = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Advance the u0 LFSR model using the inputs the coming edge will sample,
  // then step to just after that edge.
  task automatic tick();
    if (rst)      m_lfsr = 16'hACE1;
    else if (sl0) m_lfsr = (si0 == '0) ? 16'hACE1 : si0;
    else          m_lfsr = lfsr16_next(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one u0 draw, predicted from the model ----------------
  task automatic draw0(input bit hold_req);
    logic [4:0] c;
    logic [4:0] exp_v;
    logic [4:0] got_v;
    bit         exp_f;
    bit         done;
    int         tries;
    exp_v = '0;
    exp_f = 1'b0;
    done  = 1'b0;
    tries = 0;
    rq0 = 1'b1;
    tick();
    if (!hold_req) rq0 = 1'b0;
    while (!done) begin
      @(negedge clk);
      check_eq("draw_busy",  32'(busy0),  32'd1);
      check_eq("draw_valid", 32'(valid0), 32'd0);
      check_eq("draw_lfsr",  32'(lfsr0),  32'(m_lfsr));
      c = m_lfsr[4:0];
      if (!(c >= 5'd30 || (m_last_vld && c == m_last))) begin
        exp_v = c;
        exp_f = 1'b0;
        done  = 1'b1;
      end else if (tries == 15) begin
        exp_v = m_last_vld ? ((m_last == 5'd29) ? 5'd0 : m_last + 5'd1) : 5'd0;
        exp_f = 1'b1;
        done  = 1'b1;
      end else begin
        tries++;
      end
      tick();
    end
    rq0 = 1'b0;
    exp_q.push_back(exp_v + 5'd1);
    @(negedge clk);
    got_v = exp_q.pop_front();
    check_eq("draw_done_valid", 32'(valid0), 32'd1);
    check_eq("draw_done_busy",  32'(busy0),  32'd0);
    check_eq("draw_rand",       32'(rand0),  32'(got_v));
    check_eq("draw_fallback",   32'(fb0),    32'(exp_f));
    m_last     = exp_v;
    m_last_vld = 1'b1;
  endtask

  // Hand-derived u2 LFSR contents in DRAW cycles 2..9 (seed 8'h09)
  logic [7:0] u2_lfsr_tab [8] = '{8'h13, 8'h27, 8'h4F, 8'h9F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] prev;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_rand",  32'(rand0),  32'd0);
    check_eq("rst_valid", 32'(valid0), 32'd0);
    check_eq("rst_busy",  32'(busy0),  32'd0);
    check_eq("rst_fb",    32'(fb0),    32'd0);
    check_eq("rst_state", 32'(st0),    32'd0);
    check_eq("rst_lfsr",  32'(lfsr0),  32'h0000_ACE1);
    check_eq("rst_lfsr8", 32'(lfsr1),  32'h0000_00E1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_eq("lfsr_step1", 32'(lfsr0), 32'h0000_59C3);

    // u1: seed 01 at cycle 0, req at cycle 1, accept c=2 at cycle 2
    sl8 = 1'b1; si8 = 8'h01;
    tick();                                      // cycle 1
    sl8 = 1'b0; rq8 = 1'b1;
    @(negedge clk);
    check_eq("u1_c1_lfsr", 32'(lfsr1), 32'h01);
    check_eq("u1_c1_busy", 32'(busy1), 32'd0);
    tick();                                      // cycle 2
    rq8 = 1'b0;
    @(negedge clk);
    check_eq("u1_c2_lfsr",  32'(lfsr1),  32'h02);
    check_eq("u1_c2_busy",  32'(busy1),  32'd1);
    check_eq("u1_c2_valid", 32'(valid1), 32'd0);
    tick();                                      // cycle 3
    @(negedge clk);
    check_eq("u1_c3_valid", 32'(valid1), 32'd1);
    check_eq("u1_c3_rand",  32'(rand1),  32'd2);
    check_eq("u1_c3_fb",    32'(fb1),    32'd0);
    check_eq("u1_c3_lfsr",  32'(lfsr1),  32'h04);
    tick();                                      // cycle 4
    @(negedge clk);
    check_eq("u1_c4_valid", 32'(valid1), 32'd0);
    check_eq("u1_c4_rand",  32'(rand1),  32'd2);
    check_eq("u1_c4_lfsr",  32'(lfsr1),  32'h08);
    tick();                                      // cycle 5
    @(negedge clk);
    check_eq("u1_c5_lfsr",  32'(lfsr1),  32'h11);

    // u2 / u3: seed 09, req at cycle 1; seven rejects then accept / fallback
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sl8 = 1'b1; si8 = 8'h09;                     // cycle 0
    tick();                                      // cycle 1
    sl8 = 1'b0; rq8 = 1'b1;
    @(negedge clk);
    check_eq("u2_c1_lfsr", 32'(lfsr2), 32'h09);
    tick();
    rq8 = 1'b0;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc <= 9) check_eq("u2_draw_lfsr", 32'(lfsr2), 32'(u2_lfsr_tab[cyc-2]));
      check_eq("u2_valid", 32'(valid2), 32'(cyc == 10));
      check_eq("u2_busy",  32'(busy2),  32'(cyc < 10));
      check_eq("u3_valid", 32'(valid3), 32'(cyc == 6));
      check_eq("u3_busy",  32'(busy3),  32'(cyc < 6));
      if (cyc == 10) begin
        check_eq("u2_rand", 32'(rand2), 32'd3);
        check_eq("u2_fb",   32'(fb2),   32'd0);
      end
      if (cyc == 6) begin
        check_eq("u3_rand", 32'(rand3), 32'd1);
        check_eq("u3_fb",   32'(fb3),   32'd1);
      end
      tick();
    end

    // u0: 200 back-to-back draws, no immediate repeat, values in range
    m_last_vld = 1'b0;
    prev = 5'd0;
    for (int n = 0; n < 200; n++) begin
      draw0(1'b0);
      check_eq("norep_range", 32'(rand0 >= 5'd1 && rand0 <= 5'd30), 32'd1);
      if (n > 0) check_eq("norep_diff", 32'(rand0 == prev), 32'd0);
      prev = rand0;
    end

    // Reseed with zero in the middle of a draw: abort and fall back to SEED
    rq0 = 1'b1;
    tick();
    rq0 = 1'b0;
    sl0 = 1'b1; si0 = 16'h0000;
    @(negedge clk);
    check_eq("abort_busy_pre", 32'(busy0), 32'd1);
    tick();
    sl0 = 1'b0;
    @(negedge clk);
    check_eq("abort_busy",  32'(busy0),  32'd0);
    check_eq("abort_valid", 32'(valid0), 32'd0);
    check_eq("abort_state", 32'(st0),    32'd0);
    check_eq("abort_lfsr",  32'(lfsr0),  32'h0000_ACE1);
    check_eq("abort_rand",  32'(rand0),  32'(m_last + 5'd1));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check_eq("abort_quiet", 32'(valid0), 32'd0);
    end

    // req held high through DRAW gives exactly one valid
    draw0(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check_eq("hold_one_valid", 32'(valid0), 32'd0);
      check_eq("hold_idle",      32'(busy0),  32'd0);
    end

    // Reset in the middle of a draw clears history; the next draw ignores no-repeat
    rq0 = 1'b1;
    tick();
    rq0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_busy_pre", 32'(busy0), 32'd1);
    tick();
    rst = 1'b0;
    m_last_vld = 1'b0;
    @(negedge clk);
    check_eq("mrst_rand",  32'(rand0),  32'd0);
    check_eq("mrst_busy",  32'(busy0),  32'd0);
    check_eq("mrst_valid", 32'(valid0), 32'd0);
    check_eq("mrst_lfsr",  32'(lfsr0),  32'h0000_ACE1);
    for (int n = 0; n < 4; n++) draw0(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
